// File: rtl/unum_pkg.sv
// Shared types and constants for the 32-bit unum datapath.
package unum_pkg;
    localparam int UNUM_W       = 32;
    localparam int UNUM_MAC_LAT = 10;
    localparam logic [31:0] UNUM_NAR = 32'h8000_0000;

    typedef logic [UNUM_W-1:0] unum_t;

    typedef struct packed {
        logic  nan;
        unum_t value;
    } unum_res_t;
endpackage

// File: rtl/unum_result_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and async active-high reset.
module unum_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = push & (count_r != DEPTH_C);
    assign pop_s  = pop & (count_r != '0);
    assign count  = count_r;
    // Head is forced to zero while empty so stale entries never leak out.
    assign pop_data = (count_r != '0) ? mem_r[rd_ptr_r] : '0;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/unum_fma_stream.sv
// Valid/ready wrapper around the non-stallable unum multiply-adder core:
// operand registers, latency-matched tag line, credit-protected result FIFO.
module unum_fma_stream
    import unum_pkg::*;
#(
    parameter int LAT       = UNUM_MAC_LAT,
    parameter int OUT_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    output logic [31:0] mac_unum1,
    output logic [31:0] mac_unum2,
    output logic [31:0] mac_unum3,
    input  logic [31:0] mac_unum_o,
    input  logic        mac_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_unum,
    output logic        out_nan,
    output logic        busy,
    output logic        nan_sticky
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

    logic [CW-1:0] credits_r;
    logic [LAT:0]  tag_r;
    logic          accept_s;
    logic          pop_s;
    logic          push_s;
    unum_res_t     push_data_s;
    unum_res_t     pop_data_s;
    logic [CW-1:0] fifo_count_s;

    // One credit per FIFO slot: in-flight ops plus buffered results never exceed depth.
    assign in_ready    = (credits_r != '0) & ~rst;
    assign accept_s    = in_valid & in_ready;
    assign out_valid   = (fifo_count_s != '0);
    assign pop_s       = out_valid & out_ready;
    assign push_s      = tag_r[LAT];
    assign push_data_s = {mac_nan, mac_unum_o};
    assign out_unum    = pop_data_s.value;
    assign out_nan     = pop_data_s.nan;
    assign busy        = (credits_r != DEPTH_C);

    // Credit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_r <= DEPTH_C;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   credits_r <= credits_r - CW'(1);
                2'b01:   credits_r <= credits_r + CW'(1);
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Operand registers feeding the core
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_unum1 <= 32'h0000_0000;
            mac_unum2 <= 32'h0000_0000;
            mac_unum3 <= 32'h0000_0000;
        end else if (accept_s) begin
            mac_unum1 <= in_a;
            mac_unum2 <= in_b;
            mac_unum3 <= in_c;
        end
    end

    // Tag line: clearing it on reset discards results still inside the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r <= '0;
        end else begin
            tag_r <= {tag_r[LAT-1:0], accept_s};
        end
    end

    // Sticky NaN flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_sticky <= 1'b0;
        end else if (push_s & mac_nan) begin
            nan_sticky <= 1'b1;
        end
    end

    unum_result_fifo #(
        .WIDTH ($bits(unum_res_t)),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (pop_data_s),
        .count     (fifo_count_s)
    );
endmodule

// File: tb/tb_unum_fma_stream.sv
// Self-checking bench for unum_fma_stream with an XOR stub standing in for the core.
module tb_unum_fma_stream;
    localparam int LAT = 10;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b, in_c;
    logic [31:0] mac_unum1, mac_unum2, mac_unum3;
    logic [31:0] mac_unum_o;
    logic        mac_nan;
    logic        out_valid, out_ready;
    logic [31:0] out_unum;
    logic        out_nan, busy, nan_sticky;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    logic [32:0] model_q [$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp_unum;
        logic        exp_nan;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    unum_fma_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .mac_unum1(mac_unum1), .mac_unum2(mac_unum2), .mac_unum3(mac_unum3),
        .mac_unum_o(mac_unum_o), .mac_nan(mac_nan),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_unum(out_unum), .out_nan(out_nan),
        .busy(busy), .nan_sticky(nan_sticky)
    );

    // Core stub: LAT-edge delay line of a simple function of the operands
    logic [32:0] core_pipe [LAT];
    always_ff @(posedge clk) begin
        core_pipe[0] <= {(mac_unum1 == NAR), mac_unum1 ^ mac_unum2 ^ mac_unum3};
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign mac_nan    = core_pipe[LAT-1][32];
    assign mac_unum_o = core_pipe[LAT-1][31:0];

    function automatic logic [32:0] exp_of(logic [31:0] a, logic [31:0] b, logic [31:0] c);
        return {(a == NAR), a ^ b ^ c};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard one clock: sample handshakes mid-cycle, then advance to the next negedge.
    task automatic cycle();
        logic acc, pop;
        acc = in_valid & in_ready;
        pop = out_valid & out_ready;
        if (pop) begin
            pop_cnt++;
            if (model_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected no result", {out_nan, out_unum});
            end else begin
                check("result_order", {out_nan, out_unum}, model_q.pop_front());
            end
        end
        if (acc) begin
            acc_cnt++;
            model_q.push_back(exp_of(in_a, in_b, in_c));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && (model_q.size() != 0 || busy); k++) cycle();
        check("drain_empty", 33'(model_q.size()), 33'd0);
        check("drain_idle", {32'd0, busy}, 33'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0, pop0, seen;
        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h0000_0007, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{32'hAAAA_5555, 32'h5555_AAAA, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFE, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 32'h0; in_b = 32'h0; in_c = 32'h0;
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", {32'd0, in_ready}, 33'd0);
        check("rst_out_valid", {32'd0, out_valid}, 33'd0);
        check("rst_out", {out_nan, out_unum}, 33'd0);
        check("rst_mac1", {1'b0, mac_unum1}, 33'd0);
        check("rst_mac2", {1'b0, mac_unum2}, 33'd0);
        check("rst_mac3", {1'b0, mac_unum3}, 33'd0);
        check("rst_busy", {32'd0, busy}, 33'd0);
        check("rst_sticky", {32'd0, nan_sticky}, 33'd0);
        rst = 1'b0;
        #1;
        check("ready_after_release", {32'd0, in_ready}, 33'd1);

        // Single op latency: out_valid exactly one cycle, after edge 11
        out_ready = 1'b1;
        issue(32'h1, 32'h2, 32'h4);
        for (int j = 1; j <= 12; j++) begin
            cycle();
            check("single_valid", {32'd0, out_valid}, {32'd0, (j == 11)});
            if (j == 11) begin
                check("single_result", {out_nan, out_unum}, {1'b0, 32'h7});
                check("single_busy_before_pop", {32'd0, busy}, 33'd1);
            end
            if (j == 12) check("single_busy_after_pop", {32'd0, busy}, 33'd0);
        end

        // Table-driven vectors, one op at a time
        foreach (vecs[v]) begin
            issue(vecs[v].a, vecs[v].b, vecs[v].c);
            for (int k = 0; k < 20 && !out_valid; k++) cycle();
            check("vec_valid", {32'd0, out_valid}, 33'd1);
            check("vec_result", {out_nan, out_unum}, {vecs[v].exp_nan, vecs[v].exp_unum});
            cycle();
        end
        drain();

        // Back-to-back stream of 40 with full throughput
        pop0 = pop_cnt;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_a = 32'(i); in_b = 32'h0; in_c = 32'h0;
            check("stream_ready", {32'd0, in_ready}, 33'd1);
            cycle();
        end
        in_valid = 1'b0;
        for (int m = 0; m < 12; m++) cycle();
        check("stream_rate", 33'(pop_cnt - pop0), 33'd40);
        drain();

        // Backpressure: exactly 16 accepts, FIFO fills, then drains in order
        out_ready = 1'b0;
        acc0 = acc_cnt;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1; in_a = 32'h100 + 32'(acc_cnt - acc0); in_b = 32'h0; in_c = 32'h5;
            cycle();
        end
        check("bp_accepts", 33'(acc_cnt - acc0), 33'd16);
        check("bp_in_ready", {32'd0, in_ready}, 33'd0);
        check("bp_fifo_count", 33'(dut.fifo_count_s), 33'd16);
        in_valid = 1'b0; out_ready = 1'b1;
        pop0 = pop_cnt;
        cycle();
        check("bp_ready_after_pop", {32'd0, in_ready}, 33'd1);
        drain();
        check("bp_drained", 33'(pop_cnt - pop0), 33'd16);

        // NaN flag and sticky behaviour
        check("sticky_clear_before", {32'd0, nan_sticky}, 33'd0);
        issue(NAR, 32'h1234_0000, 32'h0000_0042);
        drain();
        check("sticky_set", {32'd0, nan_sticky}, 33'd1);
        issue(32'h3, 32'h1, 32'h0);
        drain();
        check("sticky_held", {32'd0, nan_sticky}, 33'd1);

        // Reset mid-flight discards in-flight ops
        for (int i = 0; i < 5; i++) issue(32'h50 + 32'(i), 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        model_q.delete();
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        #1;
        check("mid_rst_ready", {32'd0, in_ready}, 33'd1);
        check("mid_rst_busy", {32'd0, busy}, 33'd0);
        check("mid_rst_credits", 33'(dut.credits_r), 33'd16);
        check("mid_rst_sticky", {32'd0, nan_sticky}, 33'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            cycle();
        end
        check("mid_rst_no_output", 33'(seen), 33'd0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_a = ($urandom_range(7) == 0) ? NAR : $urandom();
            in_b = $urandom();
            in_c = $urandom();
            cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unum_fma_stream.md
# unum_fma_stream

Streaming front/back-end for the 32-bit unum multiply-adder core, which computes a*b+c over 10 pipeline stages and cannot stall. The block accepts (a, b, c) operand triples on a valid/ready interface and registers them onto the core's inputs. It tags each issued operation through a latency-matched shift register and captures the core's result and NaN flag into an output FIFO. A credit counter ensures the FIFO can never overflow, so the non-stallable core is safe behind backpressure.

## Interface
- LAT, 10: core latency in clock edges, from operand sampling to valid result.
- OUT_DEPTH, 16: result FIFO depth. Must be a power of 2 and at least LAT+1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand triple valid.
- in_ready  out  1  block can accept a triple.
- in_a / in_b / in_c  in  32 each  unum operands a, b, c.
- mac_unum1 / mac_unum2 / mac_unum3  out  32 each  registered operands driven to the core.
- mac_unum_o  in  32  core result.
- mac_nan  in  1  core NaN flag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_unum  out  32  result word at the FIFO head.
- out_nan  out  1  NaN flag at the FIFO head.
- busy  out  1  at least one operation is in flight or buffered.
- nan_sticky  out  1  set by any captured NaN result; cleared only by rst.

## Operation
- Accept: fires when in_valid & in_ready at a rising edge.
  - On accept, in_a/in_b/in_c load into mac_unum1/2/3 and tag[0] is set to 1.
  - Without an accept, the mac_unum* registers hold their value and tag[0] is set to 0.
- Tag pipeline: tag[LAT:0] shifts by one position every cycle. tag[LAT]=1 marks the cycle in which mac_unum_o/mac_nan belong to a real operation.
- Capture: when tag[LAT]=1, {mac_nan, mac_unum_o} is pushed into the FIFO on the next edge. A core output with tag[LAT]=0 is ignored.
- FIFO behaviour:
  - Show-ahead: out_unum/out_nan present the head entry.
  - out_valid = (count != 0).
  - Pop occurs on out_valid & out_ready.
- Credits:
  - credits resets to OUT_DEPTH.
  - Decrements by 1 on accept; increments by 1 on pop; unchanged when both or neither occur.
  - in_ready = (credits != 0) & ~rst.
  - In-flight operations plus FIFO entries never exceed OUT_DEPTH, so there is no overflow path and no pushing into a full FIFO.
- busy = (credits != OUT_DEPTH).
- nan_sticky is set on a push with mac_nan=1.
- Width rules:
  - credits is $clog2(OUT_DEPTH)+1 bits.
  - count is $clog2(OUT_DEPTH)+1 bits.
  - FIFO pointers are $clog2(OUT_DEPTH) bits and wrap modulo OUT_DEPTH.
- Reset (including mid-operation):
  - All tags clear; FIFO empties; credits return to OUT_DEPTH.
  - In-flight core results are discarded, since the core has no reset and its outputs are untagged.
- Reset values: in_ready 0 while rst is high; out_valid 0, out_unum 0, out_nan 0, mac_unum1/2/3 0, busy 0, nan_sticky 0.
- Results leave in issue order. No reordering, no dropping, no duplication.

## Timing
- Accept at edge k:
  - Operands are on the mac_* ports after edge k.
  - The core samples them at edge k+1.
  - The result is valid on mac_unum_o after edge k+LAT, with tag[LAT]=1 in the same cycle.
  - The FIFO is written at edge k+LAT+1.
  - out_valid rises after edge k+LAT+1 if the FIFO was empty.
- Latency from accept to out_valid is LAT+1 = 11 cycles.
- Throughput is one triple per cycle while credits are available.
- When the FIFO is full with out_ready=0, in_ready is already 0.
- The first accept after out_ready returns high can occur the cycle after the first pop.
- Push and pop in the same cycle leave count unchanged.
- Deasserting rst allows in_ready=1 in the first cycle after release.

## Structure
- Shared package `unum_pkg` holds:
  - UNUM_W=32.
  - UNUM_MAC_LAT=10.
  - UNUM_NAR=32'h80000000.
  - Typedef unum_t (32-bit).
  - Typedef unum_res_t = {nan, unum_t}.
- Sub-module `unum_result_fifo`: synchronous show-ahead FIFO, parameterized width/depth, async active-high reset, count output.
- Credit counter, tag shift register and operand registers live in the top module.

## Test plan
- Bench stub: an LAT-edge delay line returning mac_unum_o = mac_unum1^mac_unum2^mac_unum3 and mac_nan = (mac_unum1==32'h80000000).
- Single op: a=32'h1, b=32'h2, c=32'h4 accepted at edge 0, out_ready=1 -> out_valid for exactly one cycle after edge 11 with out_unum=32'h7, out_nan=0; busy falls after the pop.
- Back-to-back stream: 40 triples with out_ready=1, a=i, b=0, c=0 -> in_ready stays 1 throughout; outputs 0..39 in order at one per cycle.
- Backpressure: out_ready=0 with in_valid=1 held -> exactly 16 accepts, then in_ready=0; FIFO reaches count 16 with no overflow. Raising out_ready drains 16 entries in order and in_ready returns.
- NaN: a=32'h80000000 -> out_nan=1 on that entry; nan_sticky=1 thereafter, and a subsequent non-NaN op does not clear it.
- Reset mid-flight: 5 ops accepted, rst pulsed 3 cycles later -> no out_valid for the discarded ops; credits=16 and in_ready=1 after release.
- Integration with the real core: a=c=32'h40000000 (1.0), b=32'h40000000 -> out_unum=32'h44000000 (2.0), out_nan=0, 11 cycles after accept.
